cache_memory_nway: RTL and testbench
====================================

Name: cache_memory_nway

Overview:
- Parametrised N-way set-associative write-back cache between the CPU request port and the memory interface (MI).
- Successor to the fixed-geometry write-through cache: ways, sets, line words and data width are parameters.
- Adds dirty-line write-back, true-LRU replacement with invalid-way preference, byte-enable writes and optional hit/miss statistics.

Parameters:
- WAYS, 4, associativity; power of two, >=2.
- ADDR_INDEX_SIZE, 2, set index bits; SETS = 2**ADDR_INDEX_SIZE.
- ADDR_OFFSET_SIZE, 2, word-in-line bits; LINE_WORDS = 2**ADDR_OFFSET_SIZE.
- ADDR_TAG_SIZE, 4, tag bits.
- CPU_DATA_SIZE, 16, CPU word width; multiple of 8.
- Derived: ADDR_W = TAG+INDEX+OFFSET; LINE_W = CPU_DATA_SIZE*LINE_WORDS; BE_W = CPU_DATA_SIZE/8.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CPU_ADDR  in  ADDR_W  word address {tag, index, offset}.
- SIG_CPU_RD  in  1  read request; held until ACK.
- SIG_CPU_WR  in  1  write request; held until ACK.
- CPU_OUT_DATA  in  CPU_DATA_SIZE  write data.
- CPU_B_VAL  in  BE_W  byte enables for writes.
- CPU_IN_DATA  out  CPU_DATA_SIZE  read data, valid while ACK=1.
- ACK  out  1  one-cycle completion pulse.
- RAM_ADDR  out  TAG+INDEX  line address to MI.
- SIG_RAM_RD  out  1  line refill request.
- SIG_RAM_WR  out  1  line write-back request.
- MI_IN_DATA  out  LINE_W  write-back line data.
- MI_OUT_DATA  in  LINE_W  refill line data.
- MI_SIG_RAM_ACK  in  1  MI completion, one-cycle pulse.
- HIT_CNT  out  16  hit counter (see Optional Feature).
- MISS_CNT  out  16  miss counter (see Optional Feature).

Behaviour:
- Reset (async, immediate):
  - Outputs ACK, SIG_RAM_RD, SIG_RAM_WR, CPU_IN_DATA, RAM_ADDR, MI_IN_DATA and counters all go to 0.
  - All valid and dirty bits cleared; LRU ages set to way index; FSM to IDLE.
  - Data and tag arrays are not cleared.
  - Reset mid-refill or mid-write-back abandons the transaction; a late MI_SIG_RAM_ACK seen in IDLE is ignored.
- FSM states: IDLE, LOOKUP, WBACK, REFILL, DONE.
  - IDLE: when SIG_CPU_RD or SIG_CPU_WR is 1, latch address, data, byte enables and op, then go to LOOKUP. If both are 1, op = write.
  - LOOKUP: compare tag against all valid ways of the set.
    - Hit, read: latch the selected word into CPU_IN_DATA.
    - Hit, write: merge enabled bytes into the word and set dirty.
    - Hit: update LRU, then go to DONE.
    - Miss: choose victim = lowest-index invalid way, else the way with age WAYS-1. Dirty victim -> WBACK; otherwise -> REFILL.
  - WBACK: SIG_RAM_WR=1, RAM_ADDR={victim tag, index}, MI_IN_DATA=victim line. Hold until MI_SIG_RAM_ACK, then clear dirty and go to REFILL.
  - REFILL: SIG_RAM_RD=1, RAM_ADDR={req tag, index}. On MI_SIG_RAM_ACK, write MI_OUT_DATA into the victim line, write tag, set valid=1, dirty=0, and return to LOOKUP (guaranteed hit).
  - DONE: ACK=1 for exactly one cycle, then go to IDLE. A request still asserted in the next IDLE cycle is a new request.
- Latency (request seen at cycle 0):
  - Hit: ACK at cycle 2.
  - Clean miss: ACK 2 cycles after the refill ack.
  - Dirty miss: adds the write-back round trip.
- LRU: per-set age of log2(WAYS) bits per way; ages in a set are always a permutation of 0..WAYS-1. On access or fill of way w with age a, ways with age < a increment and way w is set to 0.
- CPU_OUT_DATA, CPU_B_VAL and CPU_ADDR changes after acceptance are ignored. A write with CPU_B_VAL=0 still counts as a hit and sets dirty.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined: HIT_CNT increments in LOOKUP on a first-pass hit; MISS_CNT increments on each miss. The post-refill LOOKUP is not counted. Both saturate at 16'hFFFF and clear on RESET.
- Undefined: HIT_CNT and MISS_CNT are tied to 0 and no counter flops are built.

Decomposition:
- Package cache_pkg holds:
  - default geometry constants;
  - derived width functions (ADDR_W, LINE_W, BE_W);
  - FSM state encoding;
  - byte-merge function.
- One sub-module, cache_lru_ages: per-set age storage, victim select with invalid preference, age update on touch. It is reset by the same async RESET.
- Tag, valid, dirty and data arrays plus the FSM remain in the top level.

Test Plan:
- After reset, read addr 0x00 with MI returning line 0x4444_3333_2222_1111 (ack after 3 cycles): one SIG_RAM_RD with RAM_ADDR=0x00, no SIG_RAM_WR, CPU_IN_DATA=0x1111. A repeat read of 0x01 gives ACK at cycle 2 with 0x2222 and no MI activity.
- Write 0xABCD with CPU_B_VAL=2'b01 to a cached word 0x2222: a read returns 0x22CD and the line is dirty.
- Fill all 4 ways of set 0 (tags 0..3), touch tag 0, then miss tag 4: tag 1 is evicted. If tag 1 is dirty, SIG_RAM_WR precedes SIG_RAM_RD with RAM_ADDR={1,0} then {4,0}.
- Assert RESET during REFILL before MI ack: SIG_RAM_RD drops at once and no ACK follows. A subsequent read of the same address misses again.
- SIG_CPU_RD and SIG_CPU_WR both high: treated as a write; data is stored and ACK is a single pulse.
- With CACHE_STATS_EN: 3 hits and 2 misses give HIT_CNT=3 and MISS_CNT=2. Without the macro both read 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared geometry defaults, width helpers, FSM encoding and byte merge
// for the N-way set-associative write-back cache.
package cache_pkg;

  localparam int DEF_WAYS        = 4;
  localparam int DEF_INDEX_SIZE  = 2;
  localparam int DEF_OFFSET_SIZE = 2;
  localparam int DEF_TAG_SIZE    = 4;
  localparam int DEF_DATA_SIZE   = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_WBACK  = 3'd2,
    ST_REFILL = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic int addr_w(input int tag_w, input int idx_w, input int off_w);
    return tag_w + idx_w + off_w;
  endfunction

  function automatic int line_w(input int data_w, input int off_w);
    return data_w * (1 << off_w);
  endfunction

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  // Words up to 64 bits; callers zero-extend and truncate around the call.
  function automatic logic [63:0] byte_merge(input logic [63:0] old_word,
                                             input logic [63:0] new_word,
                                             input logic [7:0]  be);
    logic [63:0] r;
    r = old_word;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) r[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_memory_nway_if.sv
// CPU request port and memory-interface line port of the cache.
// The slave modport is the cache; the master modport is the CPU/MI environment.
interface cache_memory_nway_if
  import cache_pkg::*;
#(
  parameter int ADDR_INDEX_SIZE  = DEF_INDEX_SIZE,
  parameter int ADDR_OFFSET_SIZE = DEF_OFFSET_SIZE,
  parameter int ADDR_TAG_SIZE    = DEF_TAG_SIZE,
  parameter int CPU_DATA_SIZE    = DEF_DATA_SIZE
);
  localparam int ADDR_W = addr_w(ADDR_TAG_SIZE, ADDR_INDEX_SIZE, ADDR_OFFSET_SIZE);
  localparam int LINE_W = line_w(CPU_DATA_SIZE, ADDR_OFFSET_SIZE);
  localparam int BE_W   = be_w(CPU_DATA_SIZE);

  logic [ADDR_W-1:0]                        CPU_ADDR;
  logic                                     SIG_CPU_RD;
  logic                                     SIG_CPU_WR;
  logic [CPU_DATA_SIZE-1:0]                 CPU_OUT_DATA;
  logic [BE_W-1:0]                          CPU_B_VAL;
  logic [CPU_DATA_SIZE-1:0]                 CPU_IN_DATA;
  logic                                     ACK;
  logic [ADDR_TAG_SIZE+ADDR_INDEX_SIZE-1:0] RAM_ADDR;
  logic                                     SIG_RAM_RD;
  logic                                     SIG_RAM_WR;
  logic [LINE_W-1:0]                        MI_IN_DATA;
  logic [LINE_W-1:0]                        MI_OUT_DATA;
  logic                                     MI_SIG_RAM_ACK;
  logic [15:0]                              HIT_CNT;
  logic [15:0]                              MISS_CNT;

  modport slave (
    input  CPU_ADDR, SIG_CPU_RD, SIG_CPU_WR, CPU_OUT_DATA, CPU_B_VAL,
    input  MI_OUT_DATA, MI_SIG_RAM_ACK,
    output CPU_IN_DATA, ACK, RAM_ADDR, SIG_RAM_RD, SIG_RAM_WR, MI_IN_DATA,
    output HIT_CNT, MISS_CNT
  );

  modport master (
    output CPU_ADDR, SIG_CPU_RD, SIG_CPU_WR, CPU_OUT_DATA, CPU_B_VAL,
    output MI_OUT_DATA, MI_SIG_RAM_ACK,
    input  CPU_IN_DATA, ACK, RAM_ADDR, SIG_RAM_RD, SIG_RAM_WR, MI_IN_DATA,
    input  HIT_CNT, MISS_CNT
  );

endinterface

// File: rtl/cache_lru_ages.sv
// Per-set true-LRU age storage: victim select preferring the lowest invalid
// way, otherwise the oldest way; touched way becomes youngest.
module cache_lru_ages #(
  parameter int WAYS  = 4,
  parameter int IDX_W = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [IDX_W-1:0]        set_idx,
  input  logic [WAYS-1:0]         valid_mask,
  input  logic                    touch,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  output logic [$clog2(WAYS)-1:0] victim_way
);
  localparam int SETS = 1 << IDX_W;
  localparam int AW   = $clog2(WAYS);

  logic [AW-1:0] age [SETS][WAYS];
  logic [AW-1:0] touch_age;

  assign touch_age = age[set_idx][touch_way];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age[s][w] <= AW'(w);
        end
      end
    end else if (touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AW'(w) == touch_way)
          age[set_idx][w] <= '0;
        else if (age[set_idx][w] < touch_age)
          age[set_idx][w] <= age[set_idx][w] + 1'b1;
      end
    end
  end

  // Descending scan so the lowest-index invalid way wins over the oldest way.
  always_comb begin
    victim_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age[set_idx][w] == AW'(WAYS - 1)) victim_way = AW'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_mask[w]) victim_way = AW'(w);
    end
  end

endmodule

// File: rtl/cache_memory_nway.sv
// N-way set-associative write-back cache with true-LRU replacement and
// byte-enable writes. Define CACHE_STATS_EN to build the hit/miss counters.
module cache_memory_nway
  import cache_pkg::*;
#(
  parameter int WAYS             = DEF_WAYS,
  parameter int ADDR_INDEX_SIZE  = DEF_INDEX_SIZE,
  parameter int ADDR_OFFSET_SIZE = DEF_OFFSET_SIZE,
  parameter int ADDR_TAG_SIZE    = DEF_TAG_SIZE,
  parameter int CPU_DATA_SIZE    = DEF_DATA_SIZE
) (
  input  logic                CLK,
  input  logic                RESET,
  cache_memory_nway_if.slave  bus
);
  localparam int TW     = ADDR_TAG_SIZE;
  localparam int IW     = ADDR_INDEX_SIZE;
  localparam int OW     = ADDR_OFFSET_SIZE;
  localparam int DW     = CPU_DATA_SIZE;
  localparam int SETS   = 1 << IW;
  localparam int LINE_W = line_w(DW, OW);
  localparam int BE_W   = be_w(DW);
  localparam int WAY_W  = $clog2(WAYS);

  state_t state, state_nxt;

  logic [TW-1:0]    req_tag;
  logic [IW-1:0]    req_idx;
  logic [OW-1:0]    req_off;
  logic [DW-1:0]    req_data;
  logic [BE_W-1:0]  req_be;
  logic             req_wr;
  logic             refill_pass;
  logic [WAY_W-1:0] victim_r;
  logic [DW-1:0]    rdata_r;

  logic [TW-1:0]     tag_arr  [SETS][WAYS];
  logic [LINE_W-1:0] data_arr [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0] valid_r, dirty_r;

  logic [WAYS-1:0]  hit_vec;
  logic             hit;
  logic [WAY_W-1:0] hit_way, victim_sel, touch_way;
  logic [DW-1:0]    hit_word, merged_word;
  logic             cpu_req, mi_done, touch;

  logic                ack_c, ram_rd_c, ram_wr_c;
  logic [TW+IW-1:0]    ram_addr_c;
  logic [LINE_W-1:0]   mi_wdata_c;

  assign cpu_req = bus.SIG_CPU_RD || bus.SIG_CPU_WR;
  assign mi_done = bus.MI_SIG_RAM_ACK;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_r[req_idx][w] && (tag_arr[req_idx][w] == req_tag);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  assign hit         = |hit_vec;
  assign hit_word    = data_arr[req_idx][hit_way][req_off*DW +: DW];
  assign merged_word = DW'(byte_merge(64'(hit_word), 64'(req_data), 8'(req_be)));

  assign touch     = ((state == ST_LOOKUP) && hit) || ((state == ST_REFILL) && mi_done);
  assign touch_way = (state == ST_REFILL) ? victim_r : hit_way;

  cache_lru_ages #(
    .WAYS  (WAYS),
    .IDX_W (IW)
  ) u_lru (
    .CLK        (CLK),
    .RESET      (RESET),
    .set_idx    (req_idx),
    .valid_mask (valid_r[req_idx]),
    .touch      (touch),
    .touch_way  (touch_way),
    .victim_way (victim_sel)
  );

  // Request capture: address/data/enables are frozen for the whole transaction.
  always_ff @(posedge CLK) begin
    if ((state == ST_IDLE) && cpu_req) begin
      {req_tag, req_idx, req_off} <= bus.CPU_ADDR;
      req_data <= bus.CPU_OUT_DATA;
      req_be   <= bus.CPU_B_VAL;
    end
  end

  // Tag and data arrays are deliberately left uninitialised; valid bits gate them.
  always_ff @(posedge CLK) begin
    if ((state == ST_LOOKUP) && hit && req_wr)
      data_arr[req_idx][hit_way][req_off*DW +: DW] <= merged_word;
    if ((state == ST_REFILL) && mi_done) begin
      data_arr[req_idx][victim_r] <= bus.MI_OUT_DATA;
      tag_arr[req_idx][victim_r]  <= req_tag;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_r     <= '0;
      dirty_r     <= '0;
      req_wr      <= 1'b0;
      refill_pass <= 1'b0;
      victim_r    <= '0;
      rdata_r     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            req_wr      <= bus.SIG_CPU_WR;
            refill_pass <= 1'b0;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            if (req_wr) dirty_r[req_idx][hit_way] <= 1'b1;
            else        rdata_r <= hit_word;
          end else begin
            victim_r <= victim_sel;
          end
        end
        ST_WBACK: begin
          if (mi_done) dirty_r[req_idx][victim_r] <= 1'b0;
        end
        ST_REFILL: begin
          if (mi_done) begin
            valid_r[req_idx][victim_r] <= 1'b1;
            dirty_r[req_idx][victim_r] <= 1'b0;
            refill_pass                <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cpu_req) state_nxt = ST_LOOKUP;
      ST_LOOKUP: begin
        if (hit)                              state_nxt = ST_DONE;
        else if (dirty_r[req_idx][victim_sel]) state_nxt = ST_WBACK;
        else                                  state_nxt = ST_REFILL;
      end
      ST_WBACK:  if (mi_done) state_nxt = ST_REFILL;
      ST_REFILL: if (mi_done) state_nxt = ST_LOOKUP;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Bus outputs decode straight from state so the async reset clears them at once.
  always_comb begin
    ack_c      = 1'b0;
    ram_rd_c   = 1'b0;
    ram_wr_c   = 1'b0;
    ram_addr_c = '0;
    mi_wdata_c = '0;
    case (state)
      ST_WBACK: begin
        ram_wr_c   = 1'b1;
        ram_addr_c = {tag_arr[req_idx][victim_r], req_idx};
        mi_wdata_c = data_arr[req_idx][victim_r];
      end
      ST_REFILL: begin
        ram_rd_c   = 1'b1;
        ram_addr_c = {req_tag, req_idx};
      end
      ST_DONE: ack_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.ACK         = ack_c;
  assign bus.SIG_RAM_RD  = ram_rd_c;
  assign bus.SIG_RAM_WR  = ram_wr_c;
  assign bus.RAM_ADDR    = ram_addr_c;
  assign bus.MI_IN_DATA  = mi_wdata_c;
  assign bus.CPU_IN_DATA = rdata_r;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // The LOOKUP that follows a refill is a guaranteed hit and is not counted.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == ST_LOOKUP) begin
      if (hit && !refill_pass) hit_cnt  <= sat_inc(hit_cnt);
      else if (!hit)           miss_cnt <= sat_inc(miss_cnt);
    end
  end

  assign bus.HIT_CNT  = hit_cnt;
  assign bus.MISS_CNT = miss_cnt;
`else
  assign bus.HIT_CNT  = '0;
  assign bus.MISS_CNT = '0;
`endif

endmodule

// File: tb/tb_cache_memory_nway.sv
// Directed bench for cache_memory_nway: refill, hits, byte writes, LRU
// eviction with write-back, reset abort, simultaneous RD/WR and statistics.
module tb_cache_memory_nway;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  cache_memory_nway_if bus ();

  cache_memory_nway dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Memory-interface responder and request log.
  bit          mi_en   = 1'b0;
  int          mi_lat  = 3;
  logic [63:0] mi_line = '0;
  bit          mi_busy = 1'b0;
  int          mi_cnt  = 0;
  int          log_n   = 0;
  bit          log_wr   [64];
  logic [5:0]  log_addr [64];
  logic [63:0] log_data [64];

  always @(negedge CLK) begin
    bus.MI_SIG_RAM_ACK = 1'b0;
    if (mi_busy) begin
      if (mi_cnt == 0) begin
        bus.MI_SIG_RAM_ACK = 1'b1;
        bus.MI_OUT_DATA    = mi_line;
        mi_busy            = 1'b0;
      end else begin
        mi_cnt--;
      end
    end else if (mi_en && (bus.SIG_RAM_RD || bus.SIG_RAM_WR)) begin
      log_wr[log_n[5:0]]   = bus.SIG_RAM_WR;
      log_addr[log_n[5:0]] = bus.RAM_ADDR;
      log_data[log_n[5:0]] = bus.MI_IN_DATA;
      log_n++;
      mi_busy = 1'b1;
      mi_cnt  = mi_lat - 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cpu_access(input logic rd, input logic wr, input logic [7:0] addr,
                            input logic [15:0] wdata, input logic [1:0] be,
                            output logic [15:0] rdata, output int cyc);
    @(negedge CLK);
    bus.CPU_ADDR     = addr;
    bus.CPU_OUT_DATA = wdata;
    bus.CPU_B_VAL    = be;
    bus.SIG_CPU_RD   = rd;
    bus.SIG_CPU_WR   = wr;
    rdata = 'x;
    cyc   = 0;
    while (cyc < 200) begin
      @(negedge CLK);
      cyc++;
      if (bus.ACK === 1'b1) begin
        rdata = bus.CPU_IN_DATA;
        break;
      end
    end
    bus.SIG_CPU_RD = 1'b0;
    bus.SIG_CPU_WR = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    checks++; if (bus.ACK !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.ACK); end
    checks++; if (bus.SIG_RAM_RD !== 1'b0) begin errors++; $display("FAIL reset_ram_rd: got %b want 0", bus.SIG_RAM_RD); end
    checks++; if (bus.SIG_RAM_WR !== 1'b0) begin errors++; $display("FAIL reset_ram_wr: got %b want 0", bus.SIG_RAM_WR); end
    checks++; if (bus.CPU_IN_DATA !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0000", bus.CPU_IN_DATA); end
    checks++; if (bus.RAM_ADDR !== 6'h0) begin errors++; $display("FAIL reset_ram_addr: got %h want 00", bus.RAM_ADDR); end
    checks++; if (bus.MI_IN_DATA !== 64'h0) begin errors++; $display("FAIL reset_mi_data: got %h want 0", bus.MI_IN_DATA); end
    checks++; if (bus.HIT_CNT !== 16'h0) begin errors++; $display("FAIL reset_hit_cnt: got %h want 0", bus.HIT_CNT); end
    checks++; if (bus.MISS_CNT !== 16'h0) begin errors++; $display("FAIL reset_miss_cnt: got %h want 0", bus.MISS_CNT); end
    RESET = 1'b0;
  endtask

  task automatic test_read_miss_hit();
    logic [15:0] rd; int cyc; int base;
    mi_en = 1'b1; mi_lat = 3; mi_line = 64'h4444_3333_2222_1111;
    base = log_n;
    cpu_access(1'b1, 1'b0, 8'h00, 16'h0, 2'b00, rd, cyc);
    checks++; if (rd !== 16'h1111) begin errors++; $display("FAIL miss_rdata: got %h want 1111", rd); end
    checks++; if (cyc !== 7) begin errors++; $display("FAIL miss_latency: got %0d want 7", cyc); end
    checks++; if (log_n - base !== 1) begin errors++; $display("FAIL miss_mi_count: got %0d want 1", log_n - base); end
    checks++; if (log_wr[base[5:0]] !== 1'b0 || log_addr[base[5:0]] !== 6'h00) begin
      errors++; $display("FAIL miss_mi_req: got wr=%b addr=%h want wr=0 addr=00", log_wr[base[5:0]], log_addr[base[5:0]]); end
    base = log_n;
    cpu_access(1'b1, 1'b0, 8'h01, 16'h0, 2'b00, rd, cyc);
    checks++; if (rd !== 16'h2222) begin errors++; $display("FAIL hit_rdata: got %h want 2222", rd); end
    checks++; if (cyc !== 2) begin errors++; $display("FAIL hit_latency: got %0d want 2", cyc); end
    checks++; if (log_n !== base) begin errors++; $display("FAIL hit_no_mi: got %0d requests want 0", log_n - base); end
  endtask

  task automatic test_byte_write();
    logic [15:0] rd; int cyc;
    cpu_access(1'b0, 1'b1, 8'h01, 16'hABCD, 2'b01, rd, cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL bytewr_latency: got %0d want 2", cyc); end
    cpu_access(1'b1, 1'b0, 8'h01, 16'h0, 2'b00, rd, cyc);
    checks++; if (rd !== 16'h22CD) begin errors++; $display("FAIL bytewr_rdata: got %h want 22cd", rd); end
  endtask

  task automatic test_lru_evict();
    logic [15:0] rd; int cyc; int base;
    mi_line = 64'h1003_1002_1001_1000;
    cpu_access(1'b1, 1'b0, 8'h10, 16'h0, 2'b00, rd, cyc);
    checks++; if (rd !== 16'h1000) begin errors++; $display("FAIL fill_tag1: got %h want 1000", rd); end
    cpu_access(1'b0, 1'b1, 8'h11, 16'h5A5A, 2'b11, rd, cyc);
    mi_line = 64'h2003_2002_2001_2000;
    cpu_access(1'b1, 1'b0, 8'h20, 16'h0, 2'b00, rd, cyc);
    mi_line = 64'h3003_3002_3001_3000;
    cpu_access(1'b1, 1'b0, 8'h30, 16'h0, 2'b00, rd, cyc);
    checks++; if (rd !== 16'h3000) begin errors++; $display("FAIL fill_tag3: got %h want 3000", rd); end
    cpu_access(1'b1, 1'b0, 8'h02, 16'h0, 2'b00, rd, cyc);
    checks++; if (rd !== 16'h3333 || cyc !== 2) begin errors++; $display("FAIL touch_tag0: got %h in %0d cycles want 3333 in 2", rd, cyc); end
    mi_line = 64'h4003_4002_4001_4000;
    base = log_n;
    cpu_access(1'b1, 1'b0, 8'h40, 16'h0, 2'b00, rd, cyc);
    checks++; if (rd !== 16'h4000) begin errors++; $display("FAIL evict_rdata: got %h want 4000", rd); end
    checks++; if (log_n - base !== 2) begin errors++; $display("FAIL evict_mi_count: got %0d want 2", log_n - base); end
    checks++; if (log_wr[base[5:0]] !== 1'b1 || log_addr[base[5:0]] !== 6'h04) begin
      errors++; $display("FAIL evict_wb_req: got wr=%b addr=%h want wr=1 addr=04", log_wr[base[5:0]], log_addr[base[5:0]]); end
    checks++; if (log_data[base[5:0]] !== 64'h1003_1002_5A5A_1000) begin
      errors++; $display("FAIL evict_wb_data: got %h want 100310025a5a1000", log_data[base[5:0]]); end
    checks++; if (log_wr[base[5:0]+6'd1] !== 1'b0 || log_addr[base[5:0]+6'd1] !== 6'h10) begin
      errors++; $display("FAIL evict_refill_req: got wr=%b addr=%h want wr=0 addr=10", log_wr[base[5:0]+6'd1], log_addr[base[5:0]+6'd1]); end
  endtask

  task automatic test_dirty_writeback();
    logic [15:0] rd; int cyc; int base;
    base = log_n;
    mi_line = 64'h5003_5002_5001_5000;
    cpu_access(1'b1, 1'b0, 8'h50, 16'h0, 2'b00, rd, cyc);
    mi_line = 64'h6003_6002_6001_6000;
    cpu_access(1'b1, 1'b0, 8'h60, 16'h0, 2'b00, rd, cyc);
    checks++; if (log_n - base !== 2 || log_wr[base[5:0]] !== 1'b0 || log_wr[base[5:0]+6'd1] !== 1'b0) begin
      errors++; $display("FAIL clean_victims: got %0d requests, wr=%b,%b want 2 refills only", log_n - base, log_wr[base[5:0]], log_wr[base[5:0]+6'd1]); end
    base = log_n;
    mi_line = 64'h7003_7002_7001_7000;
    cpu_access(1'b1, 1'b0, 8'h70, 16'h0, 2'b00, rd, cyc);
    checks++; if (rd !== 16'h7000) begin errors++; $display("FAIL tag7_rdata: got %h want 7000", rd); end
    checks++; if (log_wr[base[5:0]] !== 1'b1 || log_addr[base[5:0]] !== 6'h00 || log_data[base[5:0]] !== 64'h4444_3333_22CD_1111) begin
      errors++; $display("FAIL dirty_tag0_wb: got wr=%b addr=%h data=%h want 1 00 4444333322cd1111", log_wr[base[5:0]], log_addr[base[5:0]], log_data[base[5:0]]); end
  endtask

  task automatic test_reset_mid_refill();
    logic [15:0] rd; int cyc; int base; int acks; int waited;
    mi_en = 1'b0;
    @(negedge CLK);
    bus.CPU_ADDR = 8'h84; bus.SIG_CPU_RD = 1'b1;
    waited = 0;
    while (bus.SIG_RAM_RD !== 1'b1 && waited < 20) begin
      @(negedge CLK); waited++;
    end
    checks++; if (bus.SIG_RAM_RD !== 1'b1 || bus.RAM_ADDR !== 6'h21) begin
      errors++; $display("FAIL abort_refill_req: got rd=%b addr=%h want rd=1 addr=21", bus.SIG_RAM_RD, bus.RAM_ADDR); end
    #2 RESET = 1'b1;
    #1;
    checks++; if (bus.SIG_RAM_RD !== 1'b0 || bus.RAM_ADDR !== 6'h00) begin
      errors++; $display("FAIL abort_rd_drop: got rd=%b addr=%h want rd=0 addr=00", bus.SIG_RAM_RD, bus.RAM_ADDR); end
    bus.SIG_CPU_RD = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge CLK);
      if (bus.ACK === 1'b1) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL abort_no_ack: got %0d acks want 0", acks); end
    mi_en = 1'b1; mi_line = 64'h8003_8002_8001_8000;
    base = log_n;
    cpu_access(1'b1, 1'b0, 8'h84, 16'h0, 2'b00, rd, cyc);
    checks++; if (rd !== 16'h8000) begin errors++; $display("FAIL abort_reread: got %h want 8000", rd); end
    checks++; if (log_n - base !== 1 || log_addr[base[5:0]] !== 6'h21) begin
      errors++; $display("FAIL abort_miss_again: got %0d requests addr=%h want 1 addr=21", log_n - base, log_addr[base[5:0]]); end
  endtask

  task automatic test_rd_wr_both();
    logic [15:0] rd; int cyc;
    cpu_access(1'b1, 1'b1, 8'h85, 16'hBEEF, 2'b11, rd, cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL both_latency: got %0d want 2", cyc); end
    @(negedge CLK);
    checks++; if (bus.ACK !== 1'b0) begin errors++; $display("FAIL both_single_ack: got %b want 0", bus.ACK); end
    cpu_access(1'b1, 1'b0, 8'h85, 16'h0, 2'b00, rd, cyc);
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL both_stored: got %h want beef", rd); end
  endtask

  task automatic test_stats();
    logic [15:0] rd; int cyc;
    logic [15:0] exp_hit, exp_miss;
`ifdef CACHE_STATS_EN
    exp_hit = 16'd3; exp_miss = 16'd2;
`else
    exp_hit = 16'd0; exp_miss = 16'd0;
`endif
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    mi_line = 64'h4444_3333_2222_1111;
    cpu_access(1'b1, 1'b0, 8'h00, 16'h0, 2'b00, rd, cyc);
    cpu_access(1'b1, 1'b0, 8'h01, 16'h0, 2'b00, rd, cyc);
    cpu_access(1'b1, 1'b0, 8'h02, 16'h0, 2'b00, rd, cyc);
    mi_line = 64'h1003_1002_1001_1000;
    cpu_access(1'b1, 1'b0, 8'h10, 16'h0, 2'b00, rd, cyc);
    cpu_access(1'b1, 1'b0, 8'h11, 16'h0, 2'b00, rd, cyc);
    checks++; if (rd !== 16'h1001) begin errors++; $display("FAIL stats_rdata: got %h want 1001", rd); end
    checks++; if (bus.HIT_CNT !== exp_hit) begin errors++; $display("FAIL stats_hit_cnt: got %0d want %0d", bus.HIT_CNT, exp_hit); end
    checks++; if (bus.MISS_CNT !== exp_miss) begin errors++; $display("FAIL stats_miss_cnt: got %0d want %0d", bus.MISS_CNT, exp_miss); end
  endtask

  initial begin
    bus.CPU_ADDR     = '0;
    bus.SIG_CPU_RD   = 1'b0;
    bus.SIG_CPU_WR   = 1'b0;
    bus.CPU_OUT_DATA = '0;
    bus.CPU_B_VAL    = '0;
    test_reset();
    test_read_miss_hit();
    test_byte_write();
    test_lru_evict();
    test_dirty_writeback();
    test_reset_mid_refill();
    test_rd_wr_both();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
